// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM state type and a magnitude helper used when latching divide operands.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    // Codes 6 and 7 are accepted as no-ops.

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV_ST = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

    // Magnitude of a 32-bit value; only negates when treated as signed.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the result if non-negative.
module md_div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [33:0] diff;

    // Trial subtraction and restore decision.
    always_comb begin
        shifted = {rem_i[31:0], quo_i[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_i};
        if (!diff[33]) begin
            rem_o = diff[32:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted;
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Multiplies use a behavioural product plus a retimable register pipe;
// divides iterate a single restoring step 32 times, then fix up signs.
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned PIPE = MUL_LAT - 1;

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] ma_q, ma_d, mb_q, mb_d;
    logic        msgn_q, msgn_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d, dvs_q, dvs_d;
    logic        sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;

    logic [65:0] prod_full;
    logic [63:0] mul_res;
    logic [32:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] quo_fix, rem_fix;
    logic        div_sgn;

    // Product of the latched operands, sign-extended by one bit for mult.
    always_comb begin
        prod_full = $signed({msgn_q & ma_q[31], ma_q}) * $signed({msgn_q & mb_q[31], mb_q});
    end

    generate
        if (PIPE == 0) begin : g_no_pipe
            assign mul_res = prod_full[63:0];
        end else begin : g_pipe
            logic [63:0] pipe_q [PIPE];
            // Free-running delay line; only sampled when the counter expires.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < PIPE; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= prod_full[63:0];
                    for (int unsigned i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_res = pipe_q[PIPE-1];
        end
    endgenerate

    md_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Sign fix-up applied on the FIX edge.
    always_comb begin
        quo_fix = (sa_q ^ sb_q) ? (~quo_q + 32'd1) : quo_q;
        rem_fix = sa_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        msgn_d  = msgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        div_sgn = (op == MD_DIV);
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        MD_MULT, MD_MULTU: begin
                            ma_d    = A;
                            mb_d    = B;
                            msgn_d  = (op == MD_MULT);
                            cnt_d   = 6'(MUL_LAT - 1);
                            state_d = MD_MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            sa_d    = div_sgn & A[31];
                            sb_d    = div_sgn & B[31];
                            dz_d    = (B == '0);
                            quo_d   = md_abs(A, div_sgn);
                            dvs_d   = md_abs(B, div_sgn);
                            rem_d   = '0;
                            cnt_d   = 6'd31;
                            state_d = MD_DIV_ST;
                        end
                        default: ;
                    endcase
                end
            end
            MD_MUL: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            MD_DIV_ST: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) state_d = MD_FIX;
                    else             cnt_d   = cnt_q - 6'd1;
                end
            end
            MD_FIX: begin
                if (!flush) begin
                    // A zero divisor leaves rem = |A|, so the signed fix-up already yields A.
                    hi_d = rem_fix;
                    lo_d = dz_q ? '1 : quo_fix;
                end
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            msgn_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            msgn_q  <= msgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: an arithmetic reference model tracks
// HI/LO/busy and is compared every cycle; directed cases pin exact values.
module tb_md_unit;
    import md_pkg::*;

    localparam int MUL_LAT = 4;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi,lo} computed with plain integer arithmetic.
    function automatic logic [63:0] expect_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              ia, ib;
        case (o)
            MD_MULT: begin
                ia = a; ib = b; sa = ia; sb = ib;
                return 64'(sa * sb);
            end
            MD_MULTU: begin
                ua = a; ub = b;
                return ua * ub;
            end
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                ia = a; ib = b;
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: pending result plus remaining cycles to its write.
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    int          m_left = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            if (flush) m_left = 0;
            else begin
                m_left--;
                if (m_left == 0) begin m_hi = r_hi; m_lo = r_lo; end
            end
        end else if (start && !flush) begin
            case (op)
                MD_MTHI: m_hi = A;
                MD_MTLO: m_lo = A;
                MD_MULT, MD_MULTU: begin {r_hi, r_lo} = expect_result(op, A, B); m_left = MUL_LAT; end
                MD_DIV, MD_DIVU:   begin {r_hi, r_lo} = expect_result(op, A, B); m_left = 33; end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int k);
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    int k;

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(MD_MTHI, 32'h12345678, 32'd0);
        issue(MD_MTLO, 32'h9ABCDEF0, 32'd0);
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mthi", hi, 32'h12345678);
        check("mtlo", lo, 32'h9ABCDEF0);

        issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
        wait_idle(20, k);
        check("mult_lat", k, MUL_LAT);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFE);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle(20, k);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(60, k);
        check("div_lat", k, 33);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        issue(MD_DIVU, 32'd7, 32'd2);
        wait_idle(60, k);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(MD_DIV, 32'd5, 32'd0);
        wait_idle(60, k);
        check("div0_lat", k, 33);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'd5);
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(60, k);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'd0);

        // Flush mid-divide, with an ignored start along the way.
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(MD_MTHI, 32'hDEADBEEF, 32'd0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'h80000000);

        issue(MD_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue(MD_DIVU, 32'd1, 32'd1);
        wait_idle(60, k);
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);

        // Asynchronous reset in the middle of a multiply.
        issue(MD_MULT, 32'd3, 32'd5);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);

        // Random traffic: starts while busy, flushes, odd codes, corner operands.
        repeat (3000) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            A     = pick();
            B     = pick();
            flush = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        wait_idle(60, k);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the MIPS execute stage. It handles mult, multu, div, divu, mthi and mtlo, which the single-cycle ALU path does not cover, and owns the architectural HI/LO registers. The unit accepts one operation per start pulse and raises busy while it computes. The pipeline stalls mfhi/mflo and any new md op until busy falls.

## Interface
Parameters:
- MUL_LAT, 4: cycles from the accepting edge to the HI/LO write for mult/multu. Legal range 1..8.

Ports:
- clk  in  1  clock; single domain.
- reset  in  1  asynchronous, active-high.
- start  in  1  request; sampled on rising clk.
- op  in  3  operation code; encodings come from the package.
- A  in  32  rs operand.
- B  in  32  rt operand.
- flush  in  1  cancels an in-flight operation (exception or eret).
- busy  out  1  high while an operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States:
  - IDLE: waits for a request.
  - MUL: counts down the multiply latency.
  - DIV: performs 32 restoring-division iterations.
  - FIX: applies signs and writes the result.
- Start acceptance:
  - start is accepted only in IDLE with flush low.
  - start while busy is ignored; the operands are not captured.
- MTHI/MTLO:
  - hi (or lo) takes A at the accepting edge.
  - The unit stays in IDLE and busy never rises.
- MULT/MULTU:
  - The operands are latched, and a 64-bit signed (mult) or unsigned (multu) product is formed.
  - {hi,lo} takes the product at accept + MUL_LAT.
- DIV/DIVU:
  - At accept, the magnitudes |A| and |B| are latched (raw values for divu), together with the sign flags and a zero-divisor flag.
  - Each of the next 32 edges performs one restoring-division step on a 33-bit partial remainder.
  - The FIX edge applies signs: the quotient is negated if sign(A)^sign(B); the remainder is negated if sign(A).
  - hi = remainder, lo = quotient.
- Divide by zero (div and divu): lo = 0xFFFFFFFF, hi = A. Latency is unchanged.
- 0x80000000 / 0xFFFFFFFF (div): lo = 0x80000000, hi = 0. No trap.
- flush:
  - Forces IDLE at the next edge and clears busy.
  - hi and lo keep their prior values.
  - flush with start in the same cycle: start is ignored.
- reset: state = IDLE, busy = 0, hi = 0, lo = 0, counter = 0.

## Timing
- Latency counts from the accepting edge E0.
- mthi/mtlo: new value visible after E0; busy stays 0.
- mult/multu: busy = 1 after E0. hi/lo update and busy = 0 after E0 + MUL_LAT.
- div/divu: DIV covers E1..E32 and FIX is E33. hi/lo update and busy = 0 after E33.
- busy falls on the same edge that writes hi/lo, so a start in the following cycle is accepted. The minimum div-to-div spacing is 34 cycles.
- hi and lo never change except on a result write, an mthi/mtlo, or reset.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronous). No late write occurs after reset is released.

## Structure
- Shared package md_pkg holds:
  - op localparams: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5. Codes 6 and 7 are a no-op: accepted, no state change.
  - state encodings.
- One sub-module, md_div_step: a combinational single restoring step taking {rem[32:0], quo[31:0], divisor[31:0]} to the next values. It is instantiated once and iterated by the counter.
- The multiplier is a behavioural * followed by a (MUL_LAT-1)-deep register pipe, so synthesis can retime it.

## Test plan
- Reset then mthi A=0x12345678, then mtlo A=0x9ABCDEF0 next cycle -> hi=0x12345678, lo=0x9ABCDEF0, busy never 1.
- mult A=0xFFFFFFFF, B=2 -> after 4 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy for 33 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu A=7, B=2 -> lo=3, hi=1.
- div A=5, B=0 -> lo=0xFFFFFFFF, hi=5. div A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start a div, pulse flush at cycle 10 -> busy=0 the next cycle, hi/lo unchanged. A start pulsed at cycle 5 of the div is ignored; the result of the original div is unaffected.
- Assert reset asynchronously mid-mult -> hi=lo=0 and busy=0 immediately. No hi/lo write occurs after reset is released.
